pkt_meta_strip: RTL and testbench

- Egress counterpart of the ingress metadata-prepend path.
- Consumes the 134b PE-array output stream, in which every packet is preceded by one metadata beat. Decodes and removes that beat, then steers the packet beats to either the network TX port (toward soc_runtime) or the config port.
- Buffers beats in an internal FIFO, offers almost-full to upstream, and checks the declared length against the received byte count.

---
 rtl/pkt_meta_strip_if.sv | 30 +++
 rtl/pkt_meta_strip.sv | 243 ++++++++++++++++++++++++
 tb/tb_pkt_meta_strip.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pkt_meta_strip_if.sv
// Egress stream bundle for pkt_meta_strip: the PE-array input beat, the two
// steered output ports with their ready signals, and the status/counter outputs.
interface pkt_meta_strip_if;
  logic         i_data_valid;
  logic [133:0] i_data;
  logic         o_alf;
  logic         o_net_valid;
  logic [133:0] o_net_data;
  logic         i_net_ready;
  logic         o_conf_valid;
  logic [133:0] o_conf_data;
  logic         i_conf_ready;
  logic         o_len_err;
  logic [31:0]  o_pkt_cnt;
  logic [15:0]  o_drop_cnt;

  // Stream source and sinks (testbench / surrounding fabric)
  modport master (
    output i_data_valid, i_data, i_net_ready, i_conf_ready,
    input  o_alf, o_net_valid, o_net_data, o_conf_valid, o_conf_data,
           o_len_err, o_pkt_cnt, o_drop_cnt
  );

  // The metadata stripper itself
  modport slave (
    input  i_data_valid, i_data, i_net_ready, i_conf_ready,
    output o_alf, o_net_valid, o_net_data, o_conf_valid, o_conf_data,
           o_len_err, o_pkt_cnt, o_drop_cnt
  );
endinterface

// File: rtl/pkt_meta_strip.sv
// pkt_meta_strip: removes the metadata beat in front of every PE-array output
// packet, buffers the packet beats in a FIFO tagged with their destination and
// presents the FIFO head on either the network TX port or the config port.
// The declared length is checked against the received byte count.
module pkt_meta_strip #(
  parameter int FIFO_AW    = 6,
  parameter int ALF_MARGIN = 8
) (
  input  logic           clk_125m,
  input  logic           sys_rst_n,
  pkt_meta_strip_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  localparam int               DEPTH     = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_C   = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0] ALF_C     = (FIFO_AW + 1)'(ALF_MARGIN);
  localparam logic [1:0]       TAG_TAIL  = 2'b10;
  localparam logic [1:0]       TAG_META  = 2'b11;
  localparam logic             DEST_NET  = 1'b0;
  localparam logic             DEST_CONF = 1'b1;

  // FIFO storage: bit 134 is the destination, bits 133:0 the untouched beat
  logic [134:0]       mem_r [DEPTH];
  logic [FIFO_AW:0]   wr_ptr_r;
  logic [FIFO_AW:0]   rd_ptr_r;
  logic [FIFO_AW:0]   count_s;
  logic [FIFO_AW:0]   free_s;
  logic [FIFO_AW:0]   count_after_pop_s;
  logic [FIFO_AW-1:0] last_addr_s;
  logic [134:0]       head_s;
  logic               empty_s;
  logic               full_s;
  logic               room_s;
  logic               pop_s;
  logic               net_valid_s;
  logic               conf_valid_s;
  logic               rewrite_s;

  // Input decode
  logic               is_meta_s;
  logic               is_tail_s;
  logic [4:0]         beat_bytes_s;
  logic [16:0]        byte_sum_s;
  logic [15:0]        byte_sat_s;

  // Write-side control
  state_t             state_r;
  state_t             state_s;
  logic               dest_r;
  logic               dest_s;
  logic [11:0]        len_r;
  logic [11:0]        len_s;
  logic [15:0]        byte_cnt_r;
  logic [15:0]        byte_cnt_s;
  logic               wrote_r;
  logic               wrote_s;
  logic               take_meta_s;
  logic               want_wr_s;
  logic               want_rewrite_s;
  logic               len_err_s;
  logic               pkt_inc_s;
  logic               drop_inc_s;

  // Status outputs
  logic               len_err_r;
  logic [31:0]        pkt_cnt_r;
  logic [15:0]        drop_cnt_r;
  logic               alf_r;

  // Beat classification and saturating byte accumulation
  always_comb begin
    is_meta_s    = bus.i_data_valid & (bus.i_data[133:132] == TAG_META);
    is_tail_s    = (bus.i_data[133:132] == TAG_TAIL);
    beat_bytes_s = is_tail_s ? ({1'b0, bus.i_data[131:128]} + 5'd1) : 5'd16;
    byte_sum_s   = {1'b0, byte_cnt_r} + {12'd0, beat_bytes_s};
    byte_sat_s   = byte_sum_s[16] ? 16'hffff : byte_sum_s[15:0];
  end

  // FIFO occupancy, head presentation and pop decision
  always_comb begin
    count_s           = wr_ptr_r - rd_ptr_r;
    free_s            = DEPTH_C - count_s;
    empty_s           = (count_s == {(FIFO_AW + 1){1'b0}});
    full_s            = (count_s == DEPTH_C);
    head_s            = mem_r[rd_ptr_r[FIFO_AW-1:0]];
    net_valid_s       = ~empty_s & (head_s[134] == DEST_NET);
    conf_valid_s      = ~empty_s & (head_s[134] == DEST_CONF);
    pop_s             = (net_valid_s & bus.i_net_ready) | (conf_valid_s & bus.i_conf_ready);
    room_s            = ~full_s | pop_s;
    count_after_pop_s = count_s - {{FIFO_AW{1'b0}}, pop_s};
    last_addr_s       = wr_ptr_r[FIFO_AW-1:0] - {{(FIFO_AW - 1){1'b0}}, 1'b1};
    // Only patch the terminated packet's last beat while it is still queued
    rewrite_s         = want_rewrite_s & wrote_r &
                        (count_after_pop_s != {(FIFO_AW + 1){1'b0}});
  end

  // Write-side FSM: next state, packet context and event strobes
  always_comb begin
    state_s        = state_r;
    dest_s         = dest_r;
    len_s          = len_r;
    byte_cnt_s     = byte_cnt_r;
    wrote_s        = wrote_r;
    take_meta_s    = 1'b0;
    want_wr_s      = 1'b0;
    want_rewrite_s = 1'b0;
    len_err_s      = 1'b0;
    pkt_inc_s      = 1'b0;
    drop_inc_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (is_meta_s) begin
          take_meta_s = 1'b1;
        end else if (bus.i_data_valid) begin
          drop_inc_s = 1'b1;
          state_s    = is_tail_s ? ST_IDLE : ST_DROP;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FWD: begin
        if (is_meta_s) begin
          // Missing tail: flag it, close the queued packet, start the new one
          len_err_s      = 1'b1;
          want_rewrite_s = 1'b1;
          take_meta_s    = 1'b1;
        end else if (bus.i_data_valid) begin
          if (room_s) begin
            want_wr_s  = 1'b1;
            wrote_s    = 1'b1;
            byte_cnt_s = byte_sat_s;
            if (is_tail_s) begin
              len_err_s = (byte_sat_s != {4'd0, len_r});
              pkt_inc_s = 1'b1;
              state_s   = ST_IDLE;
            end else begin
              state_s = ST_FWD;
            end
          end else begin
            // Overflow: abandon the remainder of this packet
            drop_inc_s = 1'b1;
            state_s    = is_tail_s ? ST_IDLE : ST_DROP;
          end
        end else begin
          state_s = ST_FWD;
        end
      end
      ST_DROP: begin
        if (bus.i_data_valid & ~is_meta_s & is_tail_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DROP;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    if (take_meta_s) begin
      len_s      = bus.i_data[27:16];
      byte_cnt_s = 16'd0;
      wrote_s    = 1'b0;
      if (bus.i_data[28]) begin
        dest_s  = DEST_CONF;
        state_s = ST_FWD;
      end else if (bus.i_data[29]) begin
        dest_s  = DEST_NET;
        state_s = ST_FWD;
      end else begin
        drop_inc_s = 1'b1;
        state_s    = ST_DROP;
      end
    end else begin
      len_s = len_r;
    end
  end

  // FSM state, packet context, FIFO pointers, counters and registered status
  always_ff @(posedge clk_125m or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r    <= ST_IDLE;
      dest_r     <= DEST_NET;
      len_r      <= 12'd0;
      byte_cnt_r <= 16'd0;
      wrote_r    <= 1'b0;
      wr_ptr_r   <= {(FIFO_AW + 1){1'b0}};
      rd_ptr_r   <= {(FIFO_AW + 1){1'b0}};
      len_err_r  <= 1'b0;
      pkt_cnt_r  <= 32'd0;
      drop_cnt_r <= 16'd0;
      alf_r      <= 1'b0;
    end else begin
      state_r    <= state_s;
      dest_r     <= dest_s;
      len_r      <= len_s;
      byte_cnt_r <= byte_cnt_s;
      wrote_r    <= wrote_s;
      len_err_r  <= len_err_s;
      alf_r      <= (free_s <= ALF_C);
      if (want_wr_s) begin
        wr_ptr_r <= wr_ptr_r + {{FIFO_AW{1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{FIFO_AW{1'b0}}, 1'b1};
      end
      if (pkt_inc_s) begin
        pkt_cnt_r <= pkt_cnt_r + 32'd1;
      end
      if (drop_inc_s) begin
        drop_cnt_r <= drop_cnt_r + 16'd1;
      end
    end
  end

  // FIFO storage writes and forced-tail patch (storage itself needs no reset)
  always_ff @(posedge clk_125m) begin
    if (want_wr_s) begin
      mem_r[wr_ptr_r[FIFO_AW-1:0]] <= {dest_r, bus.i_data};
    end else if (rewrite_s) begin
      mem_r[last_addr_s][133:132] <= TAG_TAIL;
    end
  end

  // Output ports: FIFO head steered by its destination bit
  always_comb begin
    bus.o_net_valid  = net_valid_s;
    bus.o_net_data   = net_valid_s ? head_s[133:0] : {134{1'b0}};
    bus.o_conf_valid = conf_valid_s;
    bus.o_conf_data  = conf_valid_s ? head_s[133:0] : {134{1'b0}};
    bus.o_alf        = alf_r;
    bus.o_len_err    = len_err_r;
    bus.o_pkt_cnt    = pkt_cnt_r;
    bus.o_drop_cnt   = drop_cnt_r;
  end

endmodule

// File: tb/tb_pkt_meta_strip.sv
// Self-checking bench for pkt_meta_strip: randomized packet streams compared
// cycle by cycle against a packet-level reference model (one expected queue).
module tb_pkt_meta_strip;

  logic clk_125m = 1'b0;
  logic sys_rst_n;

  always #4 clk_125m = ~clk_125m;

  pkt_meta_strip_if bus();

  pkt_meta_strip #(.FIFO_AW(6), .ALF_MARGIN(8)) dut (
    .clk_125m  (clk_125m),
    .sys_rst_n (sys_rst_n),
    .bus       (bus.slave)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Stimulus: bit 134 = valid, 133:0 = beat
  logic [134:0] stim_q[$];
  int unsigned  net_pct  = 100;
  int unsigned  conf_pct = 100;

  // Reference model: expected FIFO contents {dest, beat}, dest 1 = config
  logic [134:0] mq[$];
  bit           in_pkt;
  bit           dropping;
  bit           pkt_dest;
  bit           pkt_wrote;
  int           pkt_len;
  int           pkt_bytes;
  logic [31:0]  exp_pkt_cnt;
  logic [15:0]  exp_drop_cnt;
  logic         exp_len_err;
  logic         exp_alf;

  task automatic check_val(input string tag, input logic [133:0] got, input logic [133:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [133:0] rand_beat();
    logic [159:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return t[133:0];
  endfunction

  task automatic add_meta(input bit dma, input bit conf, input int len);
    logic [133:0] b;
    b = rand_beat();
    b[133:132] = 2'b11;
    b[29] = dma;
    b[28] = conf;
    b[27:16] = len[11:0];
    stim_q.push_back({1'b1, b});
  endtask

  task automatic add_beat(input logic [1:0] tag, input logic [3:0] vt);
    logic [133:0] b;
    b = rand_beat();
    b[133:132] = tag;
    b[131:128] = vt;
    stim_q.push_back({1'b1, b});
  endtask

  task automatic add_pkt(input int nbeats, input logic [3:0] tail_vt);
    add_beat(2'b01, 4'($urandom_range(0, 15)));
    for (int i = 1; i < nbeats - 1; i++) add_beat(2'b00, 4'($urandom_range(0, 15)));
    add_beat(2'b10, tail_vt);
  endtask

  task automatic add_idle(input int n);
    for (int i = 0; i < n; i++) stim_q.push_back({1'b0, rand_beat()});
  endtask

  task automatic model_reset();
    mq.delete();
    in_pkt = 0; dropping = 0; pkt_dest = 0; pkt_wrote = 0;
    pkt_len = 0; pkt_bytes = 0;
    exp_pkt_cnt = 32'd0; exp_drop_cnt = 16'd0;
    exp_len_err = 1'b0; exp_alf = 1'b0;
  endtask

  task automatic model_meta(input logic [133:0] d);
    in_pkt = 0; dropping = 0;
    pkt_len = int'(d[27:16]); pkt_bytes = 0; pkt_wrote = 0;
    if (d[28]) begin in_pkt = 1; pkt_dest = 1; end
    else if (d[29]) begin in_pkt = 1; pkt_dest = 0; end
    else begin dropping = 1; exp_drop_cnt++; end
  endtask

  // One clock of expected behaviour, applied for the upcoming rising edge
  task automatic model_update(input bit v, input logic [133:0] d, input bit nr, input bit cr);
    int occ_before;
    bit popped;
    logic [134:0] tmp;
    logic [1:0] tag;
    occ_before = mq.size();
    exp_alf = ((64 - occ_before) <= 8);
    exp_len_err = 1'b0;
    popped = 0;
    if (mq.size() > 0) begin
      if (mq[0][134] ? cr : nr) begin
        void'(mq.pop_front());
        popped = 1;
      end
    end
    tag = d[133:132];
    if (v) begin
      if (in_pkt) begin
        if (tag == 2'b11) begin
          exp_len_err = 1'b1;
          if (pkt_wrote && mq.size() > 0) begin
            tmp = mq[mq.size() - 1];
            tmp[133:132] = 2'b10;
            mq[mq.size() - 1] = tmp;
          end
          model_meta(d);
        end else if (occ_before == 64 && !popped) begin
          exp_drop_cnt++;
          in_pkt = 0;
          dropping = (tag != 2'b10);
        end else begin
          mq.push_back({pkt_dest, d});
          pkt_wrote = 1;
          pkt_bytes += (tag == 2'b10) ? int'(d[131:128]) + 1 : 16;
          if (pkt_bytes > 65535) pkt_bytes = 65535;
          if (tag == 2'b10) begin
            exp_len_err = (pkt_bytes != pkt_len);
            exp_pkt_cnt++;
            in_pkt = 0;
          end
        end
      end else if (dropping) begin
        if (tag == 2'b10) dropping = 0;
      end else begin
        if (tag == 2'b11) model_meta(d);
        else begin
          exp_drop_cnt++;
          if (tag != 2'b10) dropping = 1;
        end
      end
    end
  endtask

  task automatic compare_outputs();
    logic env, ecv;
    logic [133:0] end_d, ecd;
    env = 1'b0; ecv = 1'b0; end_d = '0; ecd = '0;
    if (mq.size() > 0) begin
      if (mq[0][134]) begin ecv = 1'b1; ecd = mq[0][133:0]; end
      else begin env = 1'b1; end_d = mq[0][133:0]; end
    end
    check_val("net_valid", 134'(bus.o_net_valid), 134'(env));
    check_val("net_data", bus.o_net_data, end_d);
    check_val("conf_valid", 134'(bus.o_conf_valid), 134'(ecv));
    check_val("conf_data", bus.o_conf_data, ecd);
    check_val("alf", 134'(bus.o_alf), 134'(exp_alf));
    check_val("len_err", 134'(bus.o_len_err), 134'(exp_len_err));
    check_val("pkt_cnt", 134'(bus.o_pkt_cnt), 134'(exp_pkt_cnt));
    check_val("drop_cnt", 134'(bus.o_drop_cnt), 134'(exp_drop_cnt));
  endtask

  // Called at a falling edge: check, drive the next cycle, advance the model
  task automatic step();
    logic [134:0] s;
    bit nr, cr;
    compare_outputs();
    if (stim_q.size() > 0) s = stim_q.pop_front();
    else s = {1'b0, rand_beat()};
    nr = ($urandom_range(0, 99) < net_pct);
    cr = ($urandom_range(0, 99) < conf_pct);
    bus.i_data_valid = s[134];
    bus.i_data       = s[133:0];
    bus.i_net_ready  = nr;
    bus.i_conf_ready = cr;
    model_update(s[134], s[133:0], nr, cr);
    @(posedge clk_125m);
    @(negedge clk_125m);
  endtask

  task automatic run_stim();
    while (stim_q.size() > 0) step();
  endtask

  task automatic drain();
    int n;
    net_pct = 100; conf_pct = 100;
    n = 0;
    while (mq.size() > 0 && n < 500) begin step(); n++; end
    step();
    check_val("drain_net_idle", 134'(bus.o_net_valid), 134'(1'b0));
    check_val("drain_conf_idle", 134'(bus.o_conf_valid), 134'(1'b0));
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    bus.i_data_valid = 1'b0;
    bus.i_data = '0;
    bus.i_net_ready = 1'b0;
    bus.i_conf_ready = 1'b0;
    stim_q.delete();
    model_reset();
    #1;
    compare_outputs();
    @(negedge clk_125m);
    @(negedge clk_125m);
    sys_rst_n = 1'b1;
  endtask

  task automatic rand_pkt();
    int nb, good, len;
    logic [3:0] vt;
    int unsigned flags;
    nb = $urandom_range(2, 8);
    vt = 4'($urandom_range(0, 15));
    good = (nb - 1) * 16 + int'(vt) + 1;
    len = ($urandom_range(0, 3) == 0) ? good + $urandom_range(1, 20) : good;
    flags = $urandom_range(0, 3);
    if ($urandom_range(0, 9) == 0) add_beat(2'b00, 4'h0);
    add_meta(flags[0], flags[1], len);
    if ($urandom_range(0, 9) == 0) add_beat(2'b01, 4'h0);
    else add_pkt(nb, vt);
    add_idle($urandom_range(0, 2));
  endtask

  initial begin
    sys_rst_n = 1'b0;
    bus.i_data_valid = 1'b0;
    bus.i_data = '0;
    bus.i_net_ready = 1'b0;
    bus.i_conf_ready = 1'b0;
    model_reset();
    @(negedge clk_125m);
    do_reset();

    // Network packet, 64 bytes, always ready
    add_meta(1'b1, 1'b0, 64); add_pkt(4, 4'hf); add_idle(3);
    run_stim(); drain();

    // Config packets: 70 bytes matching, then declared 80 (mismatch)
    add_meta(1'b0, 1'b1, 70); add_pkt(5, 4'h5); add_idle(2);
    add_meta(1'b0, 1'b1, 80); add_pkt(5, 4'h5); add_idle(2);
    run_stim(); drain();

    // No-destination packet dropped, then a good one; headless beats in IDLE
    add_meta(1'b0, 1'b0, 64); add_pkt(4, 4'hf);
    add_meta(1'b1, 1'b0, 48); add_pkt(3, 4'hf); add_idle(2);
    add_beat(2'b01, 4'h0); add_beat(2'b00, 4'h0); add_beat(2'b10, 4'h3); add_idle(2);
    run_stim(); drain();

    // Backpressure: fill the FIFO, overflow a second packet, then release
    net_pct = 0;
    add_meta(1'b1, 1'b0, 1024); add_pkt(64, 4'hf);
    add_meta(1'b1, 1'b0, 64); add_pkt(4, 4'hf); add_idle(4);
    run_stim(); drain();

    // Truncated packet while the sink stalls (tail patched) and while it drains
    net_pct = 0;
    add_meta(1'b1, 1'b0, 48); add_beat(2'b01, 4'h0); add_beat(2'b00, 4'h0);
    add_meta(1'b0, 1'b1, 32); add_pkt(2, 4'hf); add_idle(2);
    run_stim(); drain();
    add_meta(1'b1, 1'b0, 48); add_beat(2'b01, 4'h0); add_idle(3);
    add_meta(1'b1, 1'b0, 32); add_pkt(2, 4'hf); add_idle(2);
    run_stim(); drain();

    // Random traffic with random sink readiness
    for (int r = 0; r < 60; r++) begin
      net_pct = $urandom_range(20, 100);
      conf_pct = $urandom_range(20, 100);
      rand_pkt();
      run_stim();
    end
    drain();

    // Reset with ten beats buffered mid-packet, then recover
    net_pct = 0;
    add_meta(1'b1, 1'b0, 160); add_beat(2'b01, 4'h0);
    for (int i = 0; i < 9; i++) add_beat(2'b00, 4'h0);
    run_stim(); step();
    do_reset();
    add_beat(2'b00, 4'h0); add_beat(2'b10, 4'h0);
    add_meta(1'b1, 1'b0, 40); add_pkt(3, 4'h7); add_idle(2);
    run_stim(); drain();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
